// File: rtl/countdown_pkg.sv
// Shared types and default constants for the countdown sequencer.
package countdown_pkg;

    localparam int CD_WIDTH    = 4;
    localparam int CD_DIV      = 4;
    localparam int CD_FIRE_LEN = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2,
        FIRE  = 2'd3
    } cd_state_t;

    // Counter width able to hold 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Control/observation bundle between user-control logic and the countdown
// sequencer.
//
// Signalling: there is no ready path. start is a single-cycle request that the
// sequencer samples together with load_val on a rising edge and honours only
// while idle; pause is a level; abort is a pulse or level. cd, fire, busy and
// state_dbg are registered outputs of the sequencer.
interface countdown_ctrl_if
    import countdown_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] cd;
    logic             fire;
    logic             busy;
    cd_state_t        state_dbg;

    modport master (
        input  start, load_val, pause, abort,
        output cd, fire, busy, state_dbg
    );

    modport slave (
        output start, load_val, pause, abort,
        input  cd, fire, busy, state_dbg
    );
endinterface

// File: rtl/countdown_ctrl_tick_gen.sv
// Step prescaler: counts 0 .. DIV-1 while enabled and flags the last count.
module tick_gen
    import countdown_pkg::*;
#(
    parameter int DIV = CD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            PW   = cnt_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Advance while enabled, wrap after the last count, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end
endmodule

// File: rtl/countdown_ctrl.sv
// Loadable countdown sequencer: loads a start value, steps it down once per
// DIV cycles, supports pause and abort, and emits a FIRE_LEN-cycle fire pulse.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int WIDTH    = CD_WIDTH,
    parameter int DIV      = CD_DIV,
    parameter int FIRE_LEN = CD_FIRE_LEN
) (
    input  logic             clk,
    input  logic             rst,
    countdown_ctrl_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FIRE  = 2'd3;

    localparam int            FW        = cnt_width(FIRE_LEN);
    localparam logic [FW-1:0] FIRE_LAST = FW'(FIRE_LEN - 1);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] cd_r, cd_n;
    logic [FW-1:0]    fcnt, fcnt_n;
    logic             fire_r, busy_r;
    logic             run, load, tick;

    // HOLD with pause already low counts as a live cycle, so the total
    // delay equals the number of cycles pause was high.
    assign run  = ((state == S_COUNT) || (state == S_HOLD)) && !bus.abort && !bus.pause;
    assign load = (state == S_IDLE) && bus.start && (bus.load_val != '0);

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (load),
        .tick (tick)
    );

    // Next-state, count and fire-counter decisions; abort beats pause beats tick.
    always_comb begin
        state_n = state;
        cd_n    = cd_r;
        fcnt_n  = fcnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.load_val != '0) begin
                        cd_n    = bus.load_val;
                        state_n = S_COUNT;
                    end else begin
                        cd_n    = '0;
                        fcnt_n  = '0;
                        state_n = S_FIRE;
                    end
                end
            end
            S_COUNT, S_HOLD: begin
                if (bus.abort) begin
                    cd_n    = '0;
                    state_n = S_IDLE;
                end else if (bus.pause) begin
                    state_n = S_HOLD;
                end else begin
                    state_n = S_COUNT;
                    if (tick) begin
                        if (cd_r <= WIDTH'(1)) begin
                            cd_n    = '0;
                            fcnt_n  = '0;
                            state_n = S_FIRE;
                        end else begin
                            cd_n = cd_r - WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                cd_n = '0;
                if (fcnt == FIRE_LAST) begin
                    fcnt_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    fcnt_n = fcnt + FW'(1);
                end
            end
        endcase
    end

    // State and registered outputs; fire and busy are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cd_r   <= '0;
            fcnt   <= '0;
            fire_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_n;
            cd_r   <= cd_n;
            fcnt   <= fcnt_n;
            fire_r <= (state_n == S_FIRE);
            busy_r <= (state_n != S_IDLE);
        end
    end

    assign bus.cd        = cd_r;
    assign bus.fire      = fire_r;
    assign bus.busy      = busy_r;
    assign bus.state_dbg = cd_state_t'(state);
endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with WIDTH=4, DIV=4, FIRE_LEN=2.
module tb_countdown_ctrl;
    import countdown_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    logic [3:0] exp_q[$];

    countdown_ctrl_if #(.WIDTH(4)) bus ();

    countdown_ctrl #(.WIDTH(4), .DIV(4), .FIRE_LEN(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        bus.start    = 1'b0;
        bus.load_val = '0;
        bus.pause    = 1'b0;
        bus.abort    = 1'b0;
    endtask

    // Issue start in cycle 0 and step into cycle 1.
    task automatic begin_run(input logic [3:0] v);
        bus.start    = 1'b1;
        bus.load_val = v;
        cyc          = 0;
        next();
        bus.start    = 1'b0;
        bus.load_val = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            next();
            n++;
        end
        check("idle_reached", int'(bus.busy), 0);
        next();
    endtask

    initial begin
        int first_fire;
        int seen;
        int prev;
        logic [3:0] e;

        checks = 0;
        errors = 0;
        cyc    = 0;
        clear_inputs();

        // Reset held three cycles under random inputs.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.start    = 1'($urandom_range(0, 1));
            bus.load_val = 4'($urandom_range(0, 15));
            bus.pause    = 1'($urandom_range(0, 1));
            bus.abort    = 1'($urandom_range(0, 1));
            next();
            check("rst_cd", int'(bus.cd), 0);
            check("rst_fire", int'(bus.fire), 0);
            check("rst_busy", int'(bus.busy), 0);
        end
        rst = 1'b0;
        clear_inputs();
        next();
        check("post_rst_cd", int'(bus.cd), 0);
        check("post_rst_fire", int'(bus.fire), 0);
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_state", int'(bus.state_dbg), int'(IDLE));

        // Normal countdown from 3.
        exp_q = {4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2,
                 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        begin_run(4'd3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("norm_cd", int'(bus.cd), int'(e));
            check("norm_fire", int'(bus.fire), (cyc == 13 || cyc == 14) ? 1 : 0);
            check("norm_busy", int'(bus.busy), (cyc >= 1 && cyc <= 14) ? 1 : 0);
            next();
        end

        // Zero load fires immediately.
        begin_run(4'd0);
        for (int c = 1; c <= 4; c++) begin
            check("zero_fire", int'(bus.fire), (c <= 2) ? 1 : 0);
            check("zero_cd", int'(bus.cd), 0);
            next();
        end

        // Maximum load: 15 steps, first fire at cycle 61, no wrap.
        begin_run(4'd15);
        check("max_cd_first", int'(bus.cd), 15);
        first_fire = -1;
        seen       = 0;
        prev       = 15;
        while (cyc <= 64) begin
            if (cyc == 60) check("max_cd_60", int'(bus.cd), 1);
            if (bus.fire && first_fire < 0) first_fire = cyc;
            if (int'(bus.cd) > prev) seen = 1;
            prev = int'(bus.cd);
            next();
        end
        check("max_first_fire", first_fire, 61);
        check("max_no_wrap", seen, 0);
        wait_idle();

        // Pause held over cycles 3..7.
        begin_run(4'd2);
        while (cyc <= 16) begin
            bus.pause = (cyc >= 3 && cyc <= 7);
            check("pause_cd", int'(bus.cd), (cyc <= 9) ? 2 : ((cyc <= 13) ? 1 : 0));
            check("pause_fire", int'(bus.fire), (cyc == 14 || cyc == 15) ? 1 : 0);
            if (cyc == 5) check("pause_state", int'(bus.state_dbg), int'(HOLD));
            next();
        end
        bus.pause = 1'b0;
        wait_idle();

        // Pause on the tick cycle (cycle 4) suppresses that decrement.
        begin_run(4'd3);
        while (cyc <= 6) begin
            bus.pause = (cyc == 4);
            if (cyc == 5) check("ptick_cd_5", int'(bus.cd), 3);
            if (cyc == 6) check("ptick_cd_6", int'(bus.cd), 2);
            next();
        end
        bus.pause = 1'b0;
        wait_idle();

        // Abort at cycle 6 of a countdown from 5.
        begin_run(4'd5);
        seen = 0;
        while (cyc <= 30) begin
            bus.abort = (cyc == 6);
            if (cyc == 7) begin
                check("abort_cd", int'(bus.cd), 0);
                check("abort_busy", int'(bus.busy), 0);
            end
            if (bus.fire) seen = 1;
            next();
        end
        bus.abort = 1'b0;
        check("abort_no_fire", seen, 0);

        // Start during a running countdown is ignored.
        begin_run(4'd4);
        while (cyc <= 9) begin
            bus.start    = (cyc == 3);
            bus.load_val = (cyc == 3) ? 4'd9 : 4'd0;
            if (cyc == 4) check("istart_cd_4", int'(bus.cd), 4);
            if (cyc == 5) check("istart_cd_5", int'(bus.cd), 3);
            if (cyc == 9) check("istart_cd_9", int'(bus.cd), 2);
            next();
        end
        clear_inputs();
        wait_idle();

        // Reset on the first fire cycle, then a clean restart.
        begin_run(4'd0);
        check("rfire_fire_on", int'(bus.fire), 1);
        rst = 1'b1;
        next();
        rst = 1'b0;
        check("rfire_fire", int'(bus.fire), 0);
        check("rfire_busy", int'(bus.busy), 0);
        check("rfire_cd", int'(bus.cd), 0);
        next();
        begin_run(4'd1);
        while (cyc <= 7) begin
            check("restart_cd", int'(bus.cd), (cyc <= 4) ? 1 : 0);
            check("restart_fire", int'(bus.fire), (cyc == 5 || cyc == 6) ? 1 : 0);
            check("restart_busy", int'(bus.busy), (cyc <= 6) ? 1 : 0);
            next();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
